pipelined_adder: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor with valid/ready flow control. Operands are split into CHUNK-bit slices, and one slice is resolved per pipeline stage, with the carry rippling between stages. This gives a short critical path at full throughput. It is the datapath adder for the arithmetic blocks and returns sum, carry-out and signed overflow for each accepted operation.

---
 rtl/pipelined_adder.sv | 155 +++++++++++++++
 tb/tb_pipelined_adder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice resolved per stage, carry rippling
// between stages, valid/ready flow control with the last stage acting as the output register.
module pipelined_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             car_out,
    output logic             ovf_out
);
    localparam int unsigned STAGES = WIDTH / CHUNK;

    // Per-stage fields are packed back to back into flat vectors; these give each stage's offset.
    function automatic int unsigned sum_off(input int unsigned k);
        return CHUNK * k * (k + 1) / 2;
    endfunction

    function automatic int unsigned pend_off(input int unsigned k);
        return k * WIDTH - sum_off(k);
    endfunction

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_b_eff   = sub_in ? ~b_in : b_in;
    assign w_cin_eff = sub_in | c_in;

    generate
        if (STAGES == 1) begin : g_single
            logic             r_valid;
            logic             r_carry;
            logic             r_cmsb;
            logic [WIDTH-1:0] r_sum;
            logic [WIDTH:0]   w_add;
            logic             w_cmsb;

            assign w_add  = {1'b0, a_in} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};
            assign w_cmsb = a_in[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_add[WIDTH-1];

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_valid <= 1'b0;
                    r_sum   <= '0;
                    r_carry <= 1'b0;
                    r_cmsb  <= 1'b0;
                end else if (w_advance) begin
                    r_valid <= in_valid;
                    r_sum   <= w_add[WIDTH-1:0];
                    r_carry <= w_add[WIDTH];
                    r_cmsb  <= w_cmsb;
                end
            end

            assign out_valid = r_valid;
            assign sum_out   = r_sum;
            assign car_out   = r_carry;
            assign ovf_out   = r_carry ^ r_cmsb;
        end else begin : g_multi
            localparam int unsigned SumTot  = sum_off(STAGES);
            localparam int unsigned PendTot = pend_off(STAGES);

            logic [STAGES-1:0]  r_valid;
            logic [STAGES-1:0]  r_carry;
            logic [SumTot-1:0]  r_sum;
            logic [PendTot-1:0] r_a;
            logic [PendTot-1:0] r_b;
            logic               r_cmsb;

            logic [STAGES-1:0]  w_valid_d;
            logic [STAGES-1:0]  w_carry_d;
            logic [SumTot-1:0]  w_sum_d;
            logic [PendTot-1:0] w_a_d;
            logic [PendTot-1:0] w_b_d;
            logic               w_cmsb_d;

            for (genvar k = 0; k < STAGES; k++) begin : g_stage
                localparam int unsigned SO = sum_off(k);
                localparam int unsigned PW = WIDTH - (k + 1) * CHUNK;

                logic [CHUNK-1:0] w_a_sl;
                logic [CHUNK-1:0] w_b_sl;
                logic             w_ci;
                logic [CHUNK:0]   w_add;

                if (k == 0) begin : g_first
                    assign w_a_sl       = a_in[CHUNK-1:0];
                    assign w_b_sl       = w_b_eff[CHUNK-1:0];
                    assign w_ci         = w_cin_eff;
                    assign w_valid_d[0] = in_valid;
                    assign w_a_d[PW-1:0] = a_in[WIDTH-1:CHUNK];
                    assign w_b_d[PW-1:0] = w_b_eff[WIDTH-1:CHUNK];
                end else begin : g_next
                    // Predecessor's pending slices, right-justified: slice k sits at the bottom.
                    localparam int unsigned PO = pend_off(k - 1);

                    assign w_a_sl       = r_a[PO +: CHUNK];
                    assign w_b_sl       = r_b[PO +: CHUNK];
                    assign w_ci         = r_carry[k-1];
                    assign w_valid_d[k] = r_valid[k-1];
                    assign w_sum_d[SO +: k*CHUNK] = r_sum[sum_off(k - 1) +: k*CHUNK];

                    if (PW > 0) begin : g_pend
                        assign w_a_d[pend_off(k) +: PW] = r_a[PO + CHUNK +: PW];
                        assign w_b_d[pend_off(k) +: PW] = r_b[PO + CHUNK +: PW];
                    end
                end

                assign w_add = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, w_ci};
                assign w_carry_d[k] = w_add[CHUNK];
                assign w_sum_d[SO + k*CHUNK +: CHUNK] = w_add[CHUNK-1:0];

                if (k == STAGES - 1) begin : g_last
                    assign w_cmsb_d = w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_add[CHUNK-1];
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_valid <= '0;
                    r_carry <= '0;
                    r_sum   <= '0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_cmsb  <= 1'b0;
                end else if (w_advance) begin
                    r_valid <= w_valid_d;
                    r_carry <= w_carry_d;
                    r_sum   <= w_sum_d;
                    r_a     <= w_a_d;
                    r_b     <= w_b_d;
                    r_cmsb  <= w_cmsb_d;
                end
            end

            assign out_valid = r_valid[STAGES-1];
            assign sum_out   = r_sum[sum_off(STAGES - 1) +: WIDTH];
            assign car_out   = r_carry[STAGES-1];
            assign ovf_out   = r_carry[STAGES-1] ^ r_cmsb;
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three configurations share one stimulus stream and
// each is checked against a plain-arithmetic reference model.
module tb_pipelined_adder;
    typedef logic [17:0] exp_t;  // {carry, overflow, 16-bit sum}

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, c, sub;
    logic [15:0] a, b;

    logic       rdy0, ov0, car0, ovf0;
    logic [7:0] s0;
    logic       rdy1, ov1, car1, ovf1;
    logic [15:0] s1;
    logic       rdy2, ov2, car2, ovf2;
    logic [7:0] s2;

    int   checks = 0;
    int   failures = 0;
    int   acc0 = 0;
    exp_t q0[$], q1[$], q2[$];
    logic ovr_en;
    exp_t ovr;
    logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic [9:0]  h0, h2;
    logic [17:0] h1;
    exp_t e;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(rdy0),
        .a_in(a[7:0]), .b_in(b[7:0]), .c_in(c), .sub_in(sub),
        .out_valid(ov0), .out_ready(out_ready), .sum_out(s0), .car_out(car0), .ovf_out(ovf0)
    );
    pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(rdy1),
        .a_in(a), .b_in(b), .c_in(c), .sub_in(sub),
        .out_valid(ov1), .out_ready(out_ready), .sum_out(s1), .car_out(car1), .ovf_out(ovf1)
    );
    pipelined_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(rdy2),
        .a_in(a[7:0]), .b_in(b[7:0]), .c_in(c), .sub_in(sub),
        .out_valid(ov2), .out_ready(out_ready), .sum_out(s2), .car_out(car2), .ovf_out(ovf2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Signed overflow judged by range of the signed sum, not by carries.
    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic ic, input logic isub, input int w);
        longint mask, aa, bb, ci, t, half, sa, sb, st;
        logic   ov;
        mask = (longint'(1) << w) - 1;
        aa   = longint'(ia) & mask;
        bb   = isub ? (~longint'(ib)) & mask : longint'(ib) & mask;
        ci   = isub ? 1 : longint'(ic);
        t    = aa + bb + ci;
        half = longint'(1) << (w - 1);
        sa   = (aa >= half) ? aa - 2 * half : aa;
        sb   = (bb >= half) ? bb - 2 * half : bb;
        st   = sa + sb + ci;
        ov   = (st < -half) || (st >= half);
        return {t[w], ov, 16'(t & mask)};
    endfunction

    // Scoreboard push on acceptance, pop and compare on output handshake.
    always @(negedge clk) begin
        if (st0) chk("hold_w8c4", {ov0, car0, ovf0, s0}, {1'b1, h0});
        if (st1) chk("hold_w16c4", {ov1, car1, ovf1, s1}, {1'b1, h1});
        if (st2) chk("hold_w8c8", {ov2, car2, ovf2, s2}, {1'b1, h2});
        st0 = ov0 && !out_ready && !rst;
        st1 = ov1 && !out_ready && !rst;
        st2 = ov2 && !out_ready && !rst;
        h0 = {car0, ovf0, s0};
        h1 = {car1, ovf1, s1};
        h2 = {car2, ovf2, s2};
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            chk("ready_w8c4", rdy0, !ov0 || out_ready);
            chk("ready_w16c4", rdy1, !ov1 || out_ready);
            chk("ready_w8c8", rdy2, !ov2 || out_ready);
            if (in_valid && rdy0) begin
                q0.push_back(ovr_en ? ovr : model(a, b, c, sub, 8));
                acc0++;
            end
            if (in_valid && rdy1) q1.push_back(model(a, b, c, sub, 16));
            if (in_valid && rdy2) q2.push_back(ovr_en ? ovr : model(a, b, c, sub, 8));
            if (ov0 && out_ready) begin
                if (q0.size() == 0) chk("spurious_w8c4", ov0, 0);
                else begin
                    e = q0.pop_front();
                    chk("result_w8c4", {car0, ovf0, 8'h00, s0}, e);
                end
            end
            if (ov1 && out_ready) begin
                if (q1.size() == 0) chk("spurious_w16c4", ov1, 0);
                else begin
                    e = q1.pop_front();
                    chk("result_w16c4", {car1, ovf1, s1}, e);
                end
            end
            if (ov2 && out_ready) begin
                if (q2.size() == 0) chk("spurious_w8c8", ov2, 0);
                else begin
                    e = q2.pop_front();
                    chk("result_w8c8", {car2, ovf2, 8'h00, s2}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the w8c4 instance accepts the beat.
    task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                        input logic isub, input logic use_ovr, input exp_t ex, output int waits);
        a = ia;
        b = ib;
        c = ic;
        sub = isub;
        in_valid = 1'b1;
        ovr_en = use_ovr;
        ovr = ex;
        waits = 0;
        while (waits < 50) begin
            @(negedge clk);
            if (rdy0) break;
            waits++;
        end
        if (waits == 50) chk("accept_timeout", rdy0, 1);
        tick();
        in_valid = 1'b0;
        ovr_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int acc_start;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        c = 1'b0;
        sub = 1'b0;
        ovr_en = 1'b0;
        ovr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_w8c4", {rdy0, ov0, car0, ovf0, s0}, 32'h800);
        chk("reset_w16c4", {rdy1, ov1, car1, ovf1, s1}, 32'h80000);
        chk("reset_w8c8", {rdy2, ov2, car2, ovf2, s2}, 32'h800);

        // Carry across the slice boundary, with latency check on the 2-stage instance.
        tick();
        send(16'h000F, 16'h0001, 1'b0, 1'b0, 1'b1, {2'b00, 16'h0010}, w);
        @(negedge clk);
        chk("latency_early_w8c4", ov0, 0);
        @(negedge clk);
        chk("latency_visible_w8c4", ov0, 1);
        tick();

        send(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b1, {2'b10, 16'h0000}, w);
        send(16'h007F, 16'h0001, 1'b0, 1'b0, 1'b1, {2'b01, 16'h0080}, w);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {2'b00, 16'h00FE}, w);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, {2'b00, 16'h00FE}, w);
        send(16'h0080, 16'h0001, 1'b0, 1'b1, 1'b1, {2'b11, 16'h007F}, w);
        send(16'h0080, 16'h0001, 1'b1, 1'b1, 1'b1, {2'b11, 16'h007F}, w);
        repeat (6) tick();

        // Back-pressure: out_ready low for 4 cycles while 6 beats stream in.
        fork
            begin
                int wb;
                for (int i = 0; i < 6; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, wb);
            end
            begin
                repeat (2) tick();
                out_ready = 1'b0;
                repeat (4) tick();
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 4; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, w);
            chk("throughput_w8c4", w, 0);
        end
        repeat (8) tick();

        // Reset with two beats in flight: neither may ever emerge.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, '0, w);
        send(16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0, '0, w);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("flushed_after_reset", {ov0, ov1, ov2}, 0);
        end
        tick();

        // Random sweep with random valid/ready and occasional corner operands.
        acc_start = acc0;
        for (int cyc = 0; cyc < 20000 && (acc0 - acc_start) < 1000; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: a = 16'hFFFF;
                1: a = 16'h8000;
                2: a = 16'h7FFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: b = 16'h8000;
                2: b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            c = 1'($urandom);
            sub = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("sweep_beats", (acc0 - acc_start) >= 1000, 1);

        for (int i = 0; i < 40; i++) begin
            if (q0.size() + q1.size() + q2.size() == 0) break;
            tick();
        end
        chk("drain", q0.size() + q1.size() + q2.size(), 0);
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
